// File: rtl/lzw_code_packer_if.sv
// Interface bundling the 14-bit code input and the byte-stream output handshake
// of lzw_code_packer.
interface lzw_code_packer_if;
  logic [13:0] I_compress_data;
  logic        I_compress_data_en;
  logic        I_frame_end;
  logic [7:0]  O_pack_data;
  logic        O_pack_valid;
  logic        O_pack_last;
  logic        I_pack_ready;

  modport slave (
    input  I_compress_data, I_compress_data_en, I_frame_end, I_pack_ready,
    output O_pack_data, O_pack_valid, O_pack_last
  );

  modport master (
    output I_compress_data, I_compress_data_en, I_frame_end, I_pack_ready,
    input  O_pack_data, O_pack_valid, O_pack_last
  );
endinterface

// File: rtl/lzw_code_packer.sv
// Packs 14-bit LZW codes LSB-first into bytes, buffers them in a show-ahead FIFO
// and tags the final (zero-padded) byte of each frame.
module lzw_code_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic             I_sys_clk,
  input  logic             I_sys_rst_n,
  lzw_code_packer_if.slave pk,
  input  logic             I_state_clr,
  output logic             O_overflow,
  output logic [31:0]      O_pack_byte_cnt,
  output logic [15:0]      O_drop_code_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                     state_q, state_d;
  logic [31:0]                acc_q, acc_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic                       frame_has_bytes_q, frame_has_bytes_d;
  logic [FIFO_DEPTH-1:0][8:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             fifo_cnt_q, fifo_cnt_d;
  logic                       clr_q, clr_d;
  logic                       overflow_q, overflow_d;
  logic [31:0]                byte_cnt_q, byte_cnt_d;
  logic [15:0]                drop_cnt_q, drop_cnt_d;

  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             push_last;
  logic [8:0]       push_entry;
  logic             patch_tail;
  logic [PTR_W-1:0] tail_ptr;
  logic             drain;
  logic             pad;
  logic             code_ok;
  logic             drop;
  logic             frame_ending;
  logic [31:0]      code_ext;
  logic [7:0]       pad_mask;

  assign fifo_full = (fifo_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop       = (fifo_cnt_q != '0) && pk.I_pack_ready;
  assign tail_ptr  = wr_ptr_q - PTR_W'(1);

  assign pk.O_pack_data  = mem_q[rd_ptr_q][7:0];
  assign pk.O_pack_last  = mem_q[rd_ptr_q][8];
  assign pk.O_pack_valid = (fifo_cnt_q != '0);

  assign O_overflow      = overflow_q;
  assign O_pack_byte_cnt = byte_cnt_q;
  assign O_drop_code_cnt = drop_cnt_q;

  always_comb begin
    state_d           = state_q;
    acc_d             = acc_q;
    cnt_d             = cnt_q;
    frame_has_bytes_d = frame_has_bytes_q;
    push              = 1'b0;
    pad               = 1'b0;
    code_ok           = 1'b0;
    drop              = 1'b0;
    patch_tail        = 1'b0;
    code_ext          = {18'd0, pk.I_compress_data};
    pad_mask          = 8'hFF >> (4'd8 - cnt_q[3:0]);
    frame_ending      = (state_q == ST_FLUSH) || pk.I_frame_end;
    drain             = (cnt_q >= 6'd8) && !fifo_full;

    // A code is only taken in RUN and only if the post-drain bit count still fits.
    if (pk.I_compress_data_en) begin
      if ((state_q == ST_RUN) &&
          (({1'b0, cnt_q} + 7'd14 - (drain ? 7'd8 : 7'd0)) <= 7'd32)) begin
        code_ok = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (drain) begin
      push  = 1'b1;
      acc_d = acc_q >> 8;
      cnt_d = cnt_q - 6'd8;
      if (code_ok) begin
        acc_d = (acc_q >> 8) | (code_ext << (cnt_q - 6'd8));
        cnt_d = cnt_q + 6'd6;
      end
    end else if (code_ok) begin
      acc_d = acc_q | (code_ext << cnt_q);
      cnt_d = cnt_q + 6'd14;
    end else if ((state_q == ST_FLUSH) && (cnt_q != 6'd0) && !fifo_full) begin
      pad   = 1'b1;
      push  = 1'b1;
      acc_d = '0;
      cnt_d = '0;
    end

    push_last  = push && frame_ending && (cnt_d == 6'd0);
    push_entry = {push_last, pad ? (acc_q[7:0] & pad_mask) : acc_q[7:0]};

    if (push) begin
      frame_has_bytes_d = 1'b1;
    end

    // A frame that ended byte-aligned gets its flag patched onto the newest FIFO
    // entry, but never onto a head byte that is currently stalled on the output.
    if (push_last) begin
      state_d           = ST_RUN;
      frame_has_bytes_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (pk.I_frame_end) begin
        state_d = ST_FLUSH;
      end
    end else if (cnt_q == 6'd0) begin
      if (!frame_has_bytes_q || (fifo_cnt_q == '0) ||
          ((fifo_cnt_q == (PTR_W+1)'(1)) && pop)) begin
        state_d           = ST_RUN;
        frame_has_bytes_d = 1'b0;
      end else if (fifo_cnt_q != (PTR_W+1)'(1)) begin
        patch_tail        = 1'b1;
        state_d           = ST_RUN;
        frame_has_bytes_d = 1'b0;
      end
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    clr_d      = I_state_clr;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (patch_tail) begin
      mem_d[tail_ptr][8] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      byte_cnt_d = byte_cnt_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (clr_q) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q           <= ST_RUN;
      acc_q             <= '0;
      cnt_q             <= '0;
      frame_has_bytes_q <= 1'b0;
      mem_q             <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      fifo_cnt_q        <= '0;
      clr_q             <= 1'b0;
      overflow_q        <= 1'b0;
      byte_cnt_q        <= '0;
      drop_cnt_q        <= '0;
    end else begin
      state_q           <= state_d;
      acc_q             <= acc_d;
      cnt_q             <= cnt_d;
      frame_has_bytes_q <= frame_has_bytes_d;
      mem_q             <= mem_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      fifo_cnt_q        <= fifo_cnt_d;
      clr_q             <= clr_d;
      overflow_q        <= overflow_d;
      byte_cnt_q        <= byte_cnt_d;
      drop_cnt_q        <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_lzw_code_packer.sv
// Directed scenarios for lzw_code_packer: framing, byte alignment, overflow,
// random back-pressure streaming, statistics clear and mid-frame reset.
module tb_lzw_code_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        state_clr = 1'b0;
  logic        overflow;
  logic [31:0] byte_cnt;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;
  int stall_err = 0;

  logic [8:0] got_q[$];
  logic       stalled_prev = 1'b0;
  logic [8:0] held;

  lzw_code_packer_if pk();

  lzw_code_packer #(.FIFO_DEPTH(16)) dut (
    .I_sys_clk      (clk),
    .I_sys_rst_n    (rst_n),
    .pk             (pk),
    .I_state_clr    (state_clr),
    .O_overflow     (overflow),
    .O_pack_byte_cnt(byte_cnt),
    .O_drop_code_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Collect every transferred byte and flag any change while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && (!pk.O_pack_valid || {pk.O_pack_last, pk.O_pack_data} !== held)) begin
        stall_err++;
      end
      if (pk.O_pack_valid && pk.I_pack_ready) begin
        got_q.push_back({pk.O_pack_last, pk.O_pack_data});
      end
      stalled_prev = pk.O_pack_valid && !pk.I_pack_ready;
      held = {pk.O_pack_last, pk.O_pack_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_code(input logic [13:0] code, input logic fe);
    pk.I_compress_data    = code;
    pk.I_compress_data_en = 1'b1;
    pk.I_frame_end        = fe;
    tick(1);
    pk.I_compress_data_en = 1'b0;
    pk.I_frame_end        = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (pk.O_pack_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", pk.O_pack_valid); end
    total++; if (pk.O_pack_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", pk.O_pack_data); end
    total++; if (pk.O_pack_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b want 0", pk.O_pack_last); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (byte_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    logic [8:0]  exp[4];
    logic [31:0] cnt0;
    exp = '{9'h061, 9'h080, 9'h018, 9'h100};
    pk.I_pack_ready = 1'b1;
    got_q.delete();
    cnt0 = byte_cnt;
    send_code(14'h061, 1'b0);
    tick(3);
    send_code(14'h062, 1'b0);
    tick(3);
    pk.I_frame_end = 1'b1;
    tick(1);
    pk.I_frame_end = 1'b0;
    tick(8);
    total++; if (got_q.size() != 4) begin bad++; $display("[TB] FAIL basic_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== exp[i]) begin
        bad++; $display("[TB] FAIL basic_byte%0d: got %h want %h", i, got_q[i], exp[i]);
      end
    end
    total++; if (byte_cnt - cnt0 !== 32'd4) begin bad++; $display("[TB] FAIL basic_byte_cnt: got %0d want 4", byte_cnt - cnt0); end
  endtask

  task automatic test_aligned();
    logic [8:0] exp;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_code(14'h3FFF, (i == 3));
      tick(1);
    end
    tick(10);
    total++; if (got_q.size() != 7) begin bad++; $display("[TB] FAIL aligned_count: got %0d want 7", got_q.size()); end
    for (int i = 0; i < 7; i++) begin
      exp = (i == 6) ? 9'h1FF : 9'h0FF;
      total++;
      if (got_q.size() <= i || got_q[i] !== exp) begin
        bad++; $display("[TB] FAIL aligned_byte%0d: got %h want %h", i, got_q[i], exp);
      end
    end
  endtask

  task automatic test_frame_end_with_code();
    got_q.delete();
    pk.I_pack_ready = 1'b1;
    send_code(14'h100, 1'b1);
    total++; if (pk.O_pack_valid !== 1'b0) begin bad++; $display("[TB] FAIL fe_code_latency: got valid %b want 0", pk.O_pack_valid); end
    tick(1);
    total++; if ({pk.O_pack_valid, pk.O_pack_last, pk.O_pack_data} !== 10'h200) begin
      bad++; $display("[TB] FAIL fe_code_byte0: got v/l/d %b/%b/%h want 1/0/00", pk.O_pack_valid, pk.O_pack_last, pk.O_pack_data);
    end
    tick(1);
    total++; if ({pk.O_pack_valid, pk.O_pack_last, pk.O_pack_data} !== 10'h301) begin
      bad++; $display("[TB] FAIL fe_code_byte1: got v/l/d %b/%b/%h want 1/1/01", pk.O_pack_valid, pk.O_pack_last, pk.O_pack_data);
    end
    tick(1);
    total++; if (pk.O_pack_valid !== 1'b0) begin bad++; $display("[TB] FAIL fe_code_empty: got valid %b want 0", pk.O_pack_valid); end
    total++; if (got_q.size() != 2) begin bad++; $display("[TB] FAIL fe_code_count: got %0d want 2", got_q.size()); end
  endtask

  task automatic test_overflow();
    logic [13:0] codes[12];
    logic [8:0]  exp_q[$];
    logic [8:0]  e;
    bit          bits[$];
    logic [15:0] drop0;
    logic [31:0] cnt0;
    int          nbytes;
    drop0 = drop_cnt;
    cnt0  = byte_cnt;
    got_q.delete();
    pk.I_pack_ready = 1'b0;
    for (int i = 0; i < 12; i++) codes[i] = 14'(i * 1187 + 613);
    for (int i = 0; i < 12; i++) begin
      send_code(codes[i], 1'b0);
      tick(1);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    total++; if (drop_cnt - drop0 !== 16'd1) begin bad++; $display("[TB] FAIL ovf_drop_cnt: got %0d want 1", drop_cnt - drop0); end
    total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL ovf_stalled: got %0d bytes want 0", got_q.size()); end
    pk.I_pack_ready = 1'b1;
    pk.I_frame_end  = 1'b1;
    tick(1);
    pk.I_frame_end  = 1'b0;
    tick(30);
    for (int i = 0; i < 11; i++)
      for (int b = 0; b < 14; b++) bits.push_back(codes[i][b]);
    while (bits.size() % 8 != 0) bits.push_back(1'b0);
    nbytes = bits.size() / 8;
    for (int k = 0; k < nbytes; k++) begin
      e = '0;
      for (int b = 0; b < 8; b++) e[b] = bits[8*k + b];
      e[8] = (k == nbytes - 1);
      exp_q.push_back(e);
    end
    total++; if (got_q.size() != nbytes) begin bad++; $display("[TB] FAIL ovf_count: got %0d want %0d", got_q.size(), nbytes); end
    for (int k = 0; k < nbytes; k++) begin
      total++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k]) begin
        bad++; $display("[TB] FAIL ovf_byte%0d: got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
    total++; if (byte_cnt - cnt0 !== 32'(nbytes)) begin bad++; $display("[TB] FAIL ovf_byte_cnt: got %0d want %0d", byte_cnt - cnt0, nbytes); end
  endtask

  task automatic test_clear();
    pk.I_pack_ready = 1'b0;
    got_q.delete();
    send_code(14'h1234, 1'b1);
    tick(4);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL clr_pre_overflow: got %b want 1", overflow); end
    state_clr       = 1'b1;
    pk.I_pack_ready = 1'b1;
    tick(1);
    state_clr = 1'b0;
    tick(1);
    pk.I_pack_ready = 1'b0;
    total++; if (byte_cnt !== 32'd0) begin bad++; $display("[TB] FAIL clr_byte_cnt: got %0d want 0", byte_cnt); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL clr_overflow: got %b want 0", overflow); end
    total++; if (got_q.size() != 2 || got_q[0] !== 9'h034 || got_q[1] !== 9'h112) begin
      bad++; $display("[TB] FAIL clr_bytes: got %0d bytes %h %h want 034 112", got_q.size(), got_q[0], got_q[1]);
    end
  endtask

  task automatic test_random_stream();
    logic [13:0] sent[$];
    logic [13:0] c;
    bit          bits[$];
    int          budget;
    int          nlast;
    logic [15:0] drop0;
    drop0 = drop_cnt;
    got_q.delete();
    for (int i = 0; i < 1000; i++) begin
      c = 14'($urandom);
      sent.push_back(c);
      pk.I_pack_ready = ($urandom_range(0, 3) != 0);
      send_code(c, (i == 999));
      for (int g = 0; g < 3; g++) begin
        pk.I_pack_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
    end
    pk.I_pack_ready = 1'b1;
    budget = 0;
    while (got_q.size() < 1750 && budget < 300) begin
      tick(1);
      budget++;
    end
    total++; if (got_q.size() != 1750) begin bad++; $display("[TB] FAIL rand_count: got %0d want 1750", got_q.size()); end
    total++; if (drop_cnt - drop0 !== 16'd0) begin bad++; $display("[TB] FAIL rand_drops: got %0d want 0", drop_cnt - drop0); end
    total++; if (stall_err != 0) begin bad++; $display("[TB] FAIL rand_stall_stable: got %0d changes want 0", stall_err); end
    nlast = 0;
    foreach (got_q[k]) begin
      nlast += int'(got_q[k][8]);
      for (int b = 0; b < 8; b++) bits.push_back(got_q[k][b]);
    end
    total++; if (nlast != 1 || got_q.size() == 0 || got_q[got_q.size()-1][8] !== 1'b1) begin
      bad++; $display("[TB] FAIL rand_last: got %0d last flags want 1 on final byte", nlast);
    end
    for (int i = 0; i < 1000; i++) begin
      c = '0;
      if (bits.size() >= 14*(i+1)) begin
        for (int b = 0; b < 14; b++) c[b] = bits[14*i + b];
      end
      total++;
      if (bits.size() < 14*(i+1) || c !== sent[i]) begin
        bad++; $display("[TB] FAIL rand_code%0d: got %h want %h", i, c, sent[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    pk.I_pack_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_code(14'(i * 211 + 77), 1'b0);
      tick(1);
    end
    tick(2);
    total++; if (pk.O_pack_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_valid: got %b want 1", pk.O_pack_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (pk.O_pack_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid: got %b want 0", pk.O_pack_valid); end
    total++; if (byte_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rst_byte_cnt: got %0d want 0", byte_cnt); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    got_q.delete();
    pk.I_pack_ready = 1'b1;
    send_code(14'h2A5, 1'b1);
    tick(6);
    total++; if (got_q.size() != 2 || got_q[0] !== 9'h0A5 || got_q[1] !== 9'h102) begin
      bad++; $display("[TB] FAIL rst_new_frame: got %0d bytes %h %h want 0a5 102", got_q.size(), got_q[0], got_q[1]);
    end
  endtask

  initial begin
    pk.I_compress_data    = '0;
    pk.I_compress_data_en = 1'b0;
    pk.I_frame_end        = 1'b0;
    pk.I_pack_ready       = 1'b0;
    tick(3);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    test_reset();
    test_basic();
    test_aligned();
    test_frame_end_with_code();
    test_overflow();
    test_clear();
    test_random_stream();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
